serial_subtractor_ctrl: RTL

SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

---
 rtl/serial_sub_pkg.sv | 14 +
 rtl/fs_cell.sv | 16 +
 rtl/serial_subtractor_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and constants for the bit-serial subtractor
package serial_sub_pkg;

  // Operand width used when the instantiating design does not override WIDTH
  localparam int SUB_WIDTH_DEFAULT = 8;

  // Controller states: wait for start, shift one bit per cycle, present result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/fs_cell.sv
// rtl/fs_cell.sv - one-bit full subtractor (combinational)
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out of a - b - bin
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// rtl/serial_subtractor_ctrl.sv - bit-serial a-b controller; optional ovf output under SERIAL_SUB_OVF_EN
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow
);

  // Counter must hold the value WIDTH without wrapping
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             step_d;
  logic             step_bout;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted away during RUN, so keep copies for ovf
  logic             a_sign;
  logic             b_sign;
`endif

  // Single full-subtract cell working on the current LSBs and the borrow flop
  fs_cell u_fs_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (step_d),
    .bout (step_bout)
  );

  // Controller FSM with all outputs registered; results change only on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_sign <= a[WIDTH-1];
            b_sign <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= {step_d, res[WIDTH-1:1]};
          br  <= step_bout;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            // Final bit: publish the full result in the same edge
            diff   <= {step_d, res[WIDTH-1:1]};
            borrow <= step_bout;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= (a_sign ^ b_sign) & (step_d ^ a_sign);
`endif
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
